j_chunk_fetcher: RTL

Memory-side producer for the energy matrix-multiply datapath.
- On start, it walks the J matrix in memory one MEM_BANDWIDTH-wide word per chunk and issues req/gnt read requests.
- It absorbs variable read latency in a small FIFO and presents chunks to the consumer with a valid/ready handshake.
- It supports early abort when the consumer's energy check terminates the pass.

---
 rtl/j_fetch_pkg.sv | 29 ++
 rtl/j_chunk_fetcher_sync_fifo.sv | 59 +++++
 rtl/j_chunk_fetcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/j_fetch_pkg.sv
// Shared constants and types for the J-matrix chunk fetcher.
// Optional feature macro used by the top: FETCH_PERF_CNT_EN.
package j_fetch_pkg;

  localparam int MEM_BANDWIDTH   = 4096;
  localparam int VECTOR_SIZE     = 256;
  localparam int J_ELEMENT_WIDTH = 4;
  localparam int ADDR_WIDTH      = 16;
  localparam int FIFO_DEPTH      = 4;

  localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH);
  localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ;

  localparam int CHUNK_IDX_W = $clog2(NUM_J_CHUNKS);
  localparam int REQ_CNT_W   = $clog2(NUM_J_CHUNKS + 1);
  localparam int CREDIT_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  // Bit offset of element (row k, col i) inside one chunk word.
  function automatic int unsigned j_elem_offset(input int unsigned k, input int unsigned i);
    return (k * J_COLS_PER_READ + i) * J_ELEMENT_WIDTH;
  endfunction

endpackage

// File: rtl/j_chunk_fetcher_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count/pointers,
  // which keeps the array a plain RAM/register file without reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/j_chunk_fetcher.sv
// Walks the J matrix one memory word per chunk and streams chunks to the consumer.
// Optional stall/wait performance counters are built when FETCH_PERF_CNT_EN is defined.
module j_chunk_fetcher
  import j_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     mem_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [MEM_BANDWIDTH-1:0] mem_rdata,
  output logic                     chunk_valid,
  input  logic                     chunk_ready,
  output logic [MEM_BANDWIDTH-1:0] chunk_data,
  output logic [CHUNK_IDX_W-1:0]   chunk_idx,
  output logic                     chunk_last
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              mem_wait_cycles
`endif
);

  localparam int SUM_W = CREDIT_W + 1;

  fetch_state_e             state;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [REQ_CNT_W-1:0]     req_cnt;
  logic [REQ_CNT_W-1:0]     out_cnt;
  logic [CREDIT_W-1:0]      outstanding;
  logic [CREDIT_W-1:0]      fifo_count;
  logic [MEM_BANDWIDTH-1:0] fifo_head;
  logic                     fifo_empty;
  logic                     in_fetch;
  logic                     start_ok;
  logic                     credit_ok;
  logic                     grant;
  logic                     push;
  logic                     pop;
  logic                     flush;

  assign in_fetch = (state == FETCH);
  assign start_ok = (state == IDLE) && start;

  // In-flight reads plus buffered words never exceed the FIFO, so a return always has a slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
  assign mem_req   = in_fetch && !abort && (req_cnt < REQ_CNT_W'(NUM_J_CHUNKS)) && credit_ok;
  assign mem_addr  = base_q + ADDR_WIDTH'(req_cnt);
  assign grant     = mem_req && mem_gnt;

  assign push        = in_fetch && mem_rvalid;
  assign flush       = start_ok || (in_fetch && abort);
  assign chunk_valid = in_fetch && !fifo_empty;
  assign pop         = chunk_valid && chunk_ready;
  assign chunk_data  = chunk_valid ? fifo_head : '0;
  assign chunk_idx   = out_cnt[CHUNK_IDX_W-1:0];
  assign chunk_last  = (out_cnt == REQ_CNT_W'(NUM_J_CHUNKS - 1));
  assign busy        = (state != IDLE);

  sync_fifo #(
    .WIDTH (MEM_BANDWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            req_cnt     <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
            state       <= abort ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          outstanding <= outstanding + CREDIT_W'(grant) - CREDIT_W'(mem_rvalid);
          if (abort) begin
            state <= DRAIN;
          end else begin
            req_cnt <= req_cnt + REQ_CNT_W'(grant);
            out_cnt <= out_cnt + REQ_CNT_W'(pop);
            if (pop && chunk_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Returns still owed by memory are swallowed before the pass may end.
          if (mem_rvalid && outstanding != '0) begin
            outstanding <= outstanding - CREDIT_W'(1);
          end else if (!mem_rvalid && outstanding == '0) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      mem_wait_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles    <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (chunk_valid && !chunk_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (in_fetch && fifo_empty && out_cnt < REQ_CNT_W'(NUM_J_CHUNKS) && mem_wait_cycles != '1)
        mem_wait_cycles <= mem_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
